// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end of the 19-bit pipelined CPU.
//
// Owns the PC and the IF/ID pipeline register. Honours hazard-detector stall
// requests (PCwrite / IF_IDwrite), branch redirect + flush from EX, freezes
// fetch on a HALT opcode, and keeps saturating stall / flush counters.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   imem_addr / imem_data    instruction memory (combinational read, addr == pc)
//   PCwrite, IF_IDwrite      hazard-detector hold requests (0 = hold)
//   branch_taken/_target     redirect request from EX; flushes IF/ID
//   if_id_instr/_pc/_valid   IF/ID pipeline register
//   IF_rs, IF_rt             source-register fields of if_id_instr
//   halted                   fetch frozen by HALT
//   stall_cnt, flush_cnt     saturating performance counters
module fetch_stage #(
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [4:0]         HALT_OP  = 5'b11111,
    parameter int                 CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [18:0]       imem_data,
    input  logic              PCwrite,
    input  logic              IF_IDwrite,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [18:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic              if_id_valid,
    output logic [2:0]        IF_rs,
    output logic [2:0]        IF_rt,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [ADDR_W-1:0] r_pc;
    logic [18:0]       r_instr;
    logic [ADDR_W-1:0] r_ifpc;
    logic              r_valid;
    logic              r_halted;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_is_halt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_stall_sat;
    logic              w_flush_sat;

    assign w_is_halt   = (imem_data[18:14] == HALT_OP);
    assign w_pc_inc    = r_pc + 1'b1;   // wraps naturally at ADDR_W bits
    assign w_stall_sat = &r_stall_cnt;
    assign w_flush_sat = &r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_instr     <= '0;
            r_ifpc      <= '0;
            r_valid     <= 1'b0;
            r_halted    <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (branch_taken) begin
            // Flush wins over any stall request and releases a HALT.
            r_pc     <= branch_target;
            r_instr  <= '0;
            r_ifpc   <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            if (!w_flush_sat)
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end else if (r_halted) begin
            // Frozen: PC holds, IF/ID drains to a NOP and stays there.
            r_instr <= '0;
            r_valid <= 1'b0;
        end else begin
            if (IF_IDwrite) begin
                r_instr <= imem_data;
                r_ifpc  <= r_pc;
                r_valid <= 1'b1;
                if (w_is_halt)
                    r_halted <= 1'b1;
            end else if (!w_stall_sat) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            // A HALT word entering IF/ID pins the PC at its own address.
            if (PCwrite && !(IF_IDwrite && w_is_halt))
                r_pc <= w_pc_inc;
        end
    end

    assign imem_addr   = r_pc;
    assign if_id_instr = r_instr;
    assign if_id_pc    = r_ifpc;
    assign if_id_valid = r_valid;
    assign IF_rs       = r_instr[13:11];
    assign IF_rt       = r_instr[10:8];
    assign halted      = r_halted;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---- default-parameter DUT ----
    logic        rst, PCwrite, IF_IDwrite, branch_taken;
    logic [15:0] branch_target, imem_addr, if_id_pc, stall_cnt, flush_cnt;
    logic [18:0] imem_data, if_id_instr;
    logic        if_id_valid, halted;
    logic [2:0]  IF_rs, IF_rt;
    logic [18:0] mem [256];

    assign imem_data = mem[imem_addr[7:0]];

    fetch_stage u_dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .PCwrite(PCwrite), .IF_IDwrite(IF_IDwrite), .branch_taken(branch_taken),
        .branch_target(branch_target), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_valid(if_id_valid), .IF_rs(IF_rs), .IF_rt(IF_rt), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // ---- narrow DUT for wrap / saturation ----
    logic        s_rst, s_pcw, s_ifw, s_br;
    logic [3:0]  s_tgt, s_addr, s_ipc;
    logic [18:0] s_data, s_instr;
    logic        s_valid, s_halted;
    logic [2:0]  s_rs, s_rt;
    logic [1:0]  s_stall, s_flush;

    assign s_data = 19'h00100;

    fetch_stage #(.ADDR_W(4), .CNT_W(2)) u_small (
        .clk(clk), .rst(s_rst), .imem_addr(s_addr), .imem_data(s_data),
        .PCwrite(s_pcw), .IF_IDwrite(s_ifw), .branch_taken(s_br),
        .branch_target(s_tgt), .if_id_instr(s_instr), .if_id_pc(s_ipc),
        .if_id_valid(s_valid), .IF_rs(s_rs), .IF_rt(s_rt), .halted(s_halted),
        .stall_cnt(s_stall), .flush_cnt(s_flush)
    );

    int total = 0;
    int bad   = 0;

    // ---- reference model state ----
    logic [15:0] m_pc, m_ipc, m_stall, m_flush;
    logic [18:0] m_instr;
    logic        m_valid, m_halted;

    task automatic model_step(input logic r, input logic pcw, input logic ifw,
                              input logic br, input logic [15:0] tgt, input logic [18:0] d);
        logic [15:0] old_pc;
        logic        hw;
        old_pc = m_pc;
        hw     = (d[18:14] == 5'h1F);
        if (r) begin
            m_pc = 0; m_ipc = 0; m_instr = 0; m_valid = 0; m_halted = 0; m_stall = 0; m_flush = 0;
        end else if (br) begin
            m_pc = tgt; m_ipc = 0; m_instr = 0; m_valid = 0; m_halted = 0;
            if (m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
        end else if (m_halted) begin
            m_instr = 0; m_valid = 0;
        end else begin
            if (ifw) begin
                m_instr = d; m_ipc = old_pc; m_valid = 1;
                if (hw) m_halted = 1;
            end else if (m_stall != 16'hFFFF) begin
                m_stall = m_stall + 16'd1;
            end
            if (pcw && !(ifw && hw)) m_pc = old_pc + 16'd1;
        end
    endtask

    task automatic cyc(input logic r, input logic pcw, input logic ifw,
                       input logic br, input logic [15:0] tgt);
        rst = r; PCwrite = pcw; IF_IDwrite = ifw; branch_taken = br; branch_target = tgt;
        @(posedge clk); #1;
    endtask

    task automatic s_cyc(input logic r, input logic pcw, input logic ifw,
                         input logic br, input logic [3:0] tgt);
        s_rst = r; s_pcw = pcw; s_ifw = ifw; s_br = br; s_tgt = tgt;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        cyc(1, 1, 1, 0, 16'h0);
        total++; if (imem_addr !== 16'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", imem_addr); end
        total++; if (if_id_instr !== 19'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", if_id_instr); end
        total++; if (if_id_pc !== 16'h0) begin bad++; $display("FAIL reset_ifpc got=%h exp=0", if_id_pc); end
        total++; if ({if_id_valid, halted} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {if_id_valid, halted}); end
        total++; if ({stall_cnt, flush_cnt} !== 32'h0) begin bad++; $display("FAIL reset_cnts got=%h exp=0", {stall_cnt, flush_cnt}); end
    endtask

    task automatic test_free_run;
        repeat (3) cyc(0, 1, 1, 0, 16'h0);
        total++; if (if_id_instr !== 19'h102) begin bad++; $display("FAIL run_instr got=%h exp=102", if_id_instr); end
        total++; if (if_id_pc !== 16'd2) begin bad++; $display("FAIL run_ifpc got=%h exp=2", if_id_pc); end
        total++; if (imem_addr !== 16'd3) begin bad++; $display("FAIL run_pc got=%h exp=3", imem_addr); end
        total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL run_valid got=%b exp=1", if_id_valid); end
        total++; if ({stall_cnt, flush_cnt} !== 32'h0) begin bad++; $display("FAIL run_cnts got=%h exp=0", {stall_cnt, flush_cnt}); end
    endtask

    task automatic test_stall;
        logic [2:0] rs0, rt0;
        repeat (2) cyc(0, 1, 1, 0, 16'h0);
        total++; if (imem_addr !== 16'd5) begin bad++; $display("FAIL stall_pre_pc got=%h exp=5", imem_addr); end
        rs0 = IF_rs; rt0 = IF_rt;
        repeat (2) cyc(0, 0, 0, 0, 16'h0);
        total++; if (imem_addr !== 16'd5) begin bad++; $display("FAIL stall_pc got=%h exp=5", imem_addr); end
        total++; if (if_id_pc !== 16'd4) begin bad++; $display("FAIL stall_ifpc got=%h exp=4", if_id_pc); end
        total++; if (if_id_instr !== 19'h104) begin bad++; $display("FAIL stall_instr got=%h exp=104", if_id_instr); end
        total++; if ({IF_rs, IF_rt} !== {rs0, rt0}) begin bad++; $display("FAIL stall_rsrt got=%h exp=%h", {IF_rs, IF_rt}, {rs0, rt0}); end
        total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL stall_cnt got=%0d exp=2", stall_cnt); end
        cyc(0, 1, 1, 0, 16'h0);
        total++; if (imem_addr !== 16'd6) begin bad++; $display("FAIL stall_resume_pc got=%h exp=6", imem_addr); end
        total++; if (if_id_pc !== 16'd5) begin bad++; $display("FAIL stall_resume_ifpc got=%h exp=5", if_id_pc); end
    endtask

    task automatic test_branch_stall;
        cyc(0, 0, 0, 1, 16'h20);
        total++; if (imem_addr !== 16'h20) begin bad++; $display("FAIL br_pc got=%h exp=20", imem_addr); end
        total++; if ({if_id_valid, if_id_instr, if_id_pc} !== 36'h0) begin bad++; $display("FAIL br_flush got=%h exp=0", {if_id_valid, if_id_instr, if_id_pc}); end
        total++; if (flush_cnt !== 16'd1) begin bad++; $display("FAIL br_flush_cnt got=%0d exp=1", flush_cnt); end
        total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL br_stall_cnt got=%0d exp=2", stall_cnt); end
        cyc(0, 1, 1, 0, 16'h0);
        total++; if (if_id_pc !== 16'h20) begin bad++; $display("FAIL br_next_ifpc got=%h exp=20", if_id_pc); end
        total++; if (if_id_instr !== 19'h120) begin bad++; $display("FAIL br_next_instr got=%h exp=120", if_id_instr); end
    endtask

    task automatic test_halt;
        mem[7] = 19'h7C000;
        cyc(0, 1, 1, 1, 16'd7);
        cyc(0, 1, 1, 0, 16'h0);
        total++; if ({if_id_valid, if_id_instr} !== {1'b1, 19'h7C000}) begin bad++; $display("FAIL halt_load got=%h exp=%h", {if_id_valid, if_id_instr}, {1'b1, 19'h7C000}); end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b exp=1", halted); end
        total++; if (imem_addr !== 16'd7) begin bad++; $display("FAIL halt_pc got=%h exp=7", imem_addr); end
        cyc(0, 1, 1, 0, 16'h0);
        cyc(0, 0, 0, 0, 16'h0);
        total++; if (imem_addr !== 16'd7) begin bad++; $display("FAIL halt_hold_pc got=%h exp=7", imem_addr); end
        total++; if ({halted, if_id_valid} !== 2'b10) begin bad++; $display("FAIL halt_nop got=%b exp=10", {halted, if_id_valid}); end
        total++; if ({stall_cnt, flush_cnt} !== {16'd2, 16'd2}) begin bad++; $display("FAIL halt_cnts got=%h exp=%h", {stall_cnt, flush_cnt}, {16'd2, 16'd2}); end
        cyc(0, 1, 1, 1, 16'h30);
        total++; if ({halted, imem_addr} !== {1'b0, 16'h30}) begin bad++; $display("FAIL halt_release got=%h exp=%h", {halted, imem_addr}, {1'b0, 16'h30}); end
        mem[7] = 19'h107;
    endtask

    task automatic test_reset_mid;
        cyc(0, 0, 0, 0, 16'h0);
        cyc(1, 0, 0, 1, 16'h55);
        total++; if ({imem_addr, if_id_pc, if_id_instr} !== 51'h0) begin bad++; $display("FAIL rstmid_regs got=%h exp=0", {imem_addr, if_id_pc, if_id_instr}); end
        total++; if ({if_id_valid, halted, stall_cnt, flush_cnt} !== 34'h0) begin bad++; $display("FAIL rstmid_flags got=%h exp=0", {if_id_valid, halted, stall_cnt, flush_cnt}); end
    endtask

    task automatic test_random;
        logic        r, pcw, ifw, br;
        logic [15:0] tgt;
        logic [18:0] d;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 19'($urandom);
            if ($urandom_range(0, 9) == 0) mem[i][18:14] = 5'h1F;
            else if (mem[i][18:14] == 5'h1F) mem[i][18:14] = 5'h0;
        end
        for (int n = 0; n < 400; n++) begin
            r   = (n == 0) || ($urandom_range(0, 49) == 0);
            br  = ($urandom_range(0, 15) == 0);
            pcw = ($urandom_range(0, 3) != 0);
            ifw = ($urandom_range(0, 3) != 0);
            tgt = 16'($urandom);
            d   = mem[m_pc[7:0]];
            cyc(r, pcw, ifw, br, tgt);
            model_step(r, pcw, ifw, br, tgt, d);
            total++; if (imem_addr !== m_pc) begin bad++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, imem_addr, m_pc); end
            total++; if ({if_id_valid, if_id_instr, if_id_pc} !== {m_valid, m_instr, m_ipc}) begin bad++; $display("FAIL rnd_ifid n=%0d got=%h exp=%h", n, {if_id_valid, if_id_instr, if_id_pc}, {m_valid, m_instr, m_ipc}); end
            total++; if ({IF_rs, IF_rt} !== {m_instr[13:11], m_instr[10:8]}) begin bad++; $display("FAIL rnd_rsrt n=%0d got=%h exp=%h", n, {IF_rs, IF_rt}, {m_instr[13:11], m_instr[10:8]}); end
            total++; if (halted !== m_halted) begin bad++; $display("FAIL rnd_halted n=%0d got=%b exp=%b", n, halted, m_halted); end
            total++; if ({stall_cnt, flush_cnt} !== {m_stall, m_flush}) begin bad++; $display("FAIL rnd_cnts n=%0d got=%h exp=%h", n, {stall_cnt, flush_cnt}, {m_stall, m_flush}); end
        end
    endtask

    task automatic test_wrap;
        s_cyc(1, 1, 1, 0, 4'h0);
        repeat (15) s_cyc(0, 1, 1, 0, 4'h0);
        total++; if (s_addr !== 4'd15) begin bad++; $display("FAIL wrap_pre got=%h exp=f", s_addr); end
        s_cyc(0, 1, 1, 0, 4'h0);
        total++; if (s_addr !== 4'd0) begin bad++; $display("FAIL wrap_pc got=%h exp=0", s_addr); end
        total++; if (s_ipc !== 4'd15) begin bad++; $display("FAIL wrap_ifpc got=%h exp=f", s_ipc); end
    endtask

    task automatic test_saturation;
        repeat (5) s_cyc(0, 0, 0, 0, 4'h0);
        total++; if (s_stall !== 2'd3) begin bad++; $display("FAIL sat_stall got=%0d exp=3", s_stall); end
        repeat (4) s_cyc(0, 1, 1, 1, 4'h3);
        total++; if (s_flush !== 2'd3) begin bad++; $display("FAIL sat_flush got=%0d exp=3", s_flush); end
        total++; if (s_stall !== 2'd3) begin bad++; $display("FAIL sat_stall_hold got=%0d exp=3", s_stall); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 19'h100 + 19'(i);
        rst = 1; PCwrite = 1; IF_IDwrite = 1; branch_taken = 0; branch_target = 0;
        s_rst = 1; s_pcw = 1; s_ifw = 1; s_br = 0; s_tgt = 0;
        m_pc = 0; m_ipc = 0; m_instr = 0; m_valid = 0; m_halted = 0; m_stall = 0; m_flush = 0;
        #1;
        test_reset;
        test_free_run;
        test_stall;
        test_branch_stall;
        test_halt;
        test_reset_mid;
        test_random;
        test_wrap;
        test_saturation;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the 19-bit pipelined CPU.
- Owns the PC and the IF/ID pipeline register, and exposes IF_rs/IF_rt for the hazard detector.
- Executes the stall requests that hazard detection issues through PCwrite and IF_IDwrite, and the branch redirect/flush requests from EX.
- Also provides HALT handling and saturating stall/flush performance counters.

Parameters:
- ADDR_W, 16: PC and instruction-memory address width (word addressed).
- RESET_PC, 0: PC value loaded on reset.
- HALT_OP, 5'b11111: opcode that halts fetch.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  ADDR_W  instruction-memory address; equals pc.
- imem_data  input  19  instruction word; combinational read of imem_addr, same cycle.
- PCwrite  input  1  1 = PC may advance; 0 = hold PC (from hazard detection).
- IF_IDwrite  input  1  1 = IF/ID may load; 0 = hold IF/ID (from hazard detection).
- branch_taken  input  1  redirect request from EX.
- branch_target  input  ADDR_W  redirect address.
- if_id_instr  output  19  registered instruction.
- if_id_pc  output  ADDR_W  PC of the registered instruction.
- if_id_valid  output  1  1 = IF/ID holds a real instruction.
- IF_rs  output  3  if_id_instr[13:11], combinational.
- IF_rt  output  3  if_id_instr[10:8], combinational.
- halted  output  1  fetch frozen by HALT.
- stall_cnt  output  CNT_W  cycles in which IF/ID was held.
- flush_cnt  output  CNT_W  number of branch flushes.

Behaviour:
- Instruction format: opcode [18:14], rs [13:11], rt [10:8], remaining bits [7:0] are not interpreted here.
- Reset (synchronous, active-high): pc=RESET_PC, if_id_instr=0, if_id_pc=0, if_id_valid=0, halted=0, stall_cnt=0, flush_cnt=0. rst asserted mid-stall or mid-branch wins over every other input.
- Per-edge priority: rst > branch_taken > halted > stall controls > normal fetch.
- branch_taken=1:
  - pc<=branch_target.
  - if_id_instr<=0, if_id_valid<=0, if_id_pc<=0.
  - halted<=0.
  - flush_cnt+=1.
  - PCwrite and IF_IDwrite are ignored that cycle: a flush overrides a stall.
- halted=1 (and no branch_taken): pc holds. IF/ID loads NOP (instr=0, valid=0) once and then holds. Neither counter changes.
- PCwrite and IF_IDwrite act independently:
  - PCwrite=0: pc holds.
  - IF_IDwrite=0: if_id_instr, if_id_pc and if_id_valid all hold; stall_cnt+=1.
- Normal fetch (PCwrite=1, IF_IDwrite=1):
  - if_id_instr<=imem_data, if_id_pc<=pc, if_id_valid<=1.
  - pc<=pc+1, wrapping modulo 2^ADDR_W; all-ones goes to 0 with no flag.
- HALT fetch: when imem_data[18:14]==HALT_OP and the IF/ID register loads it, the HALT word enters IF/ID with valid=1, pc holds (does not increment), and halted<=1. halted clears only on rst or branch_taken.
- Counters saturate at all-ones and never wrap.
- Fetch latency: instruction at address A appears on if_id_instr one edge after pc==A.
- imem_addr always equals pc. IF_rs/IF_rt track if_id_instr combinationally, including while held by a stall.

Test Plan:
- Reset then free run, imem[i]=i+0x100: after 3 edges, if_id_instr=0x102, if_id_pc=2, pc=3, valid=1, counters 0.
- Stall: at pc=5, drive PCwrite=0, IF_IDwrite=0 for 2 cycles -> pc stays 5, if_id_pc stays 4, IF_rs/IF_rt unchanged, stall_cnt=2; fetch resumes with pc=6 next edge.
- Branch during stall: PCwrite=0, IF_IDwrite=0, branch_taken=1, branch_target=0x20 -> pc=0x20, valid=0, instr=0, flush_cnt=1, stall_cnt unchanged; next edge if_id_pc=0x20.
- HALT: imem[7]=19'h7C000 -> IF/ID holds it with valid=1, halted=1, pc stays 7. Then a branch to 0x30 -> halted=0, pc=0x30.
- Wrap/saturation:
  - ADDR_W=4, pc=15 -> next pc=0.
  - CNT_W=2, 5 stall cycles -> stall_cnt=3.
- Reset mid-operation: rst=1 together with branch_taken=1 -> pc=RESET_PC, all outputs at reset values.
